// File: rtl/acc_seq_8bit.sv
// acc_seq_8bit: command sequencer wrapped around an external 8-bit add/sub stage.
// One command is taken per IDLE->EXEC->HOLD->IDLE pass. The adder inputs are
// driven straight from flops, and its result is folded back into the accumulator
// together with overflow detection and optional saturation.
//
// Handshakes: a transfer on either port happens at a rising clk edge where
// valid and ready are both 1. in_ready is high only in IDLE. out_valid rises
// on entry to HOLD, and the outputs then stay frozen until out_ready is seen.
module acc_seq_8bit #(
  parameter bit SATURATE = 1'b0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_cmd,
  input  logic [7:0]       in_data,
  input  logic             in_ci,
  output logic             add_op,
  output logic             add_ci,
  output logic [7:0]       add_x,
  output logic [7:0]       add_y,
  input  logic [7:0]       add_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_acc,
  output logic             out_of,
  output logic             sticky_of,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] CMD_ADD   = 2'b00;
  localparam logic [1:0] CMD_SUB   = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [7:0]       data_q, data_d;
  logic             ci_q, ci_d;
  logic [7:0]       acc_q, acc_d;
  logic             of_q, of_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;

  logic             is_sub;
  logic             x_msb;
  logic             y_msb;
  logic             r_msb;
  logic             ovf;
  logic [7:0]       arith_res;

  // Signed overflow of the adder result, judged on the operands actually driven out.
  always_comb begin
    is_sub = (cmd_q == CMD_SUB);
    x_msb  = acc_q[7];
    y_msb  = data_q[7];
    r_msb  = add_r[7];
    if (is_sub) begin
      ovf = (x_msb != y_msb) && (r_msb != x_msb);
    end else begin
      ovf = (x_msb == y_msb) && (r_msb != x_msb);
    end
    // On overflow the clamp direction follows the sign of the old accumulator.
    if (SATURATE && ovf) begin
      arith_res = x_msb ? 8'h80 : 8'h7F;
    end else begin
      arith_res = add_r;
    end
  end

  // Next-state and datapath update for the three-phase command sequence.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    ci_d        = ci_q;
    acc_d       = acc_q;
    of_d        = of_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          cmd_d   = in_cmd;
          data_d  = in_data;
          ci_d    = in_ci;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cmd_q)
          CMD_ADD, CMD_SUB: begin
            acc_d    = arith_res;
            of_d     = ovf;
            sticky_d = sticky_q | ovf;
          end
          CMD_LOAD: begin
            acc_d = data_q;
            of_d  = 1'b0;
          end
          CMD_CLEAR: begin
            acc_d    = 8'h00;
            of_d     = 1'b0;
            sticky_d = 1'b0;
          end
          default: begin
            acc_d = acc_q;
          end
        endcase
        cnt_d       = cnt_q + CNT_W'(1);
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        // No bypass to a new accept here: the next command waits for IDLE.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset drops any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= 2'b00;
      data_q      <= 8'h00;
      ci_q        <= 1'b0;
      acc_q       <= 8'h00;
      of_q        <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      ci_q        <= ci_d;
      acc_q       <= acc_d;
      of_q        <= of_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Adder operands come straight from flops, so they are all zero after reset.
  always_comb begin
    add_x     = acc_q;
    add_y     = data_q;
    add_op    = (cmd_q == CMD_SUB);
    add_ci    = ci_q;
    in_ready  = (state_q == S_IDLE);
    out_valid = out_valid_q;
    out_acc   = acc_q;
    out_of    = of_q;
    sticky_of = sticky_q;
    op_count  = cnt_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_acc_seq_8bit.sv
// Bench for acc_seq_8bit: a wrapping instance (CNT_W=2) and a saturating
// instance (CNT_W=8) run in lockstep on the same command stream, each with
// its own behavioural adder.
module tb_acc_seq_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_cmd;
  logic [7:0] in_data;
  logic       in_ci;
  logic       out_ready;

  logic       w_in_ready, w_add_op, w_add_ci, w_out_valid, w_out_of, w_sticky_of;
  logic [7:0] w_add_x, w_add_y, w_add_r, w_out_acc;
  logic [1:0] w_op_count, w_dbg_state;
  logic       s_in_ready, s_add_op, s_add_ci, s_out_valid, s_out_of, s_sticky_of;
  logic [7:0] s_add_x, s_add_y, s_add_r, s_out_acc, s_op_count;
  logic [1:0] s_dbg_state;

  // Behavioural adders: ci is carry-in for add, borrow-in for subtract.
  assign w_add_r = w_add_op ? (w_add_x - w_add_y - {7'b0, w_add_ci})
                            : (w_add_x + w_add_y + {7'b0, w_add_ci});
  assign s_add_r = s_add_op ? (s_add_x - s_add_y - {7'b0, s_add_ci})
                            : (s_add_x + s_add_y + {7'b0, s_add_ci});

  acc_seq_8bit #(.SATURATE(1'b0), .CNT_W(2)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_cmd(in_cmd), .in_data(in_data), .in_ci(in_ci),
    .add_op(w_add_op), .add_ci(w_add_ci), .add_x(w_add_x), .add_y(w_add_y),
    .add_r(w_add_r), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_acc(w_out_acc), .out_of(w_out_of), .sticky_of(w_sticky_of),
    .op_count(w_op_count), .dbg_state(w_dbg_state)
  );

  acc_seq_8bit #(.SATURATE(1'b1), .CNT_W(8)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_cmd(in_cmd), .in_data(in_data), .in_ci(in_ci),
    .add_op(s_add_op), .add_ci(s_add_ci), .add_x(s_add_x), .add_y(s_add_y),
    .add_r(s_add_r), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_acc(s_out_acc), .out_of(s_out_of), .sticky_of(s_sticky_of),
    .op_count(s_op_count), .dbg_state(s_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Entry layout: {op_count[7:0], sticky_of, out_of, out_acc[7:0]}
  logic [17:0] exp_w[$];
  logic [17:0] exp_s[$];
  logic [7:0]  m_acc [2];
  logic        m_st  [2];
  int          m_cnt [2];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  w_cnt8;
  assign w_cnt8 = {6'b0, w_op_count};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 8'h00;
      m_st[i]  = 1'b0;
      m_cnt[i] = 0;
    end
    exp_w.delete();
    exp_s.delete();
  endtask

  // Index 0 = wrapping CNT_W=2 instance, 1 = saturating CNT_W=8 instance.
  task automatic push_expect(input logic [1:0] cmd, input logic [7:0] d, input logic ci);
    logic [7:0] x, r;
    logic       ov;
    for (int i = 0; i < 2; i++) begin
      x  = m_acc[i];
      ov = 1'b0;
      case (cmd)
        2'b00: begin
          r  = x + d + {7'b0, ci};
          ov = (x[7] == d[7]) && (r[7] != x[7]);
        end
        2'b01: begin
          r  = x - d - {7'b0, ci};
          ov = (x[7] != d[7]) && (r[7] != x[7]);
        end
        2'b10: r = d;
        default: begin
          r = 8'h00;
          m_st[i] = 1'b0;
        end
      endcase
      if (ov && i == 1) r = x[7] ? 8'h80 : 8'h7F;
      m_acc[i] = r;
      m_st[i]  = m_st[i] | ov;
      m_cnt[i] = (m_cnt[i] + 1) % ((i == 0) ? 4 : 256);
      if (i == 0) exp_w.push_back({8'(m_cnt[i]), m_st[i], ov, r});
      else        exp_s.push_back({8'(m_cnt[i]), m_st[i], ov, r});
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at a negedge with both DUTs back in IDLE.
  task automatic run_cmd(input logic [1:0] cmd, input logic [7:0] d, input logic ci,
                         input logic early_ready, input int stall);
    int t;
    int lat;
    logic [17:0] ew, es;
    t = 0;
    while (!(w_in_ready && s_in_ready) && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 20) begin
      n_bad++;
      $display("FAIL accept_wait: in_ready=%b/%b, required 1 within 20 cycles", w_in_ready, s_in_ready);
    end
    in_valid  = 1'b1;
    in_cmd    = cmd;
    in_data   = d;
    in_ci     = ci;
    out_ready = early_ready;
    push_expect(cmd, d, ci);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!w_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 2) begin
      n_bad++;
      $display("FAIL latency: got %0d negedges to out_valid, required 2", lat);
    end
    ew = (exp_w.size() > 0) ? exp_w.pop_front() : 18'h3FFFF;
    es = (exp_s.size() > 0) ? exp_s.pop_front() : 18'h3FFFF;
    n_cmp++;
    if ({w_cnt8, w_sticky_of, w_out_of, w_out_acc} !== ew) begin
      n_bad++;
      $display("FAIL result_wrap: got cnt=%0d st=%b of=%b acc=%h, required cnt=%0d st=%b of=%b acc=%h",
               w_cnt8, w_sticky_of, w_out_of, w_out_acc, ew[17:10], ew[9], ew[8], ew[7:0]);
    end
    n_cmp++;
    if ({s_op_count, s_sticky_of, s_out_of, s_out_acc, s_out_valid} !== {es, 1'b1}) begin
      n_bad++;
      $display("FAIL result_sat: got cnt=%0d st=%b of=%b acc=%h v=%b, required cnt=%0d st=%b of=%b acc=%h v=1",
               s_op_count, s_sticky_of, s_out_of, s_out_acc, s_out_valid, es[17:10], es[9], es[8], es[7:0]);
    end
    if (stall > 0) begin
      // Offer a new command while the result is stalled; it must be ignored.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_cmd    = 2'b11;
      in_data   = 8'h5A;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        n_cmp++;
        if ({w_out_valid, w_in_ready, w_dbg_state, w_cnt8, w_sticky_of, w_out_of, w_out_acc}
            !== {1'b1, 1'b0, 2'd2, ew}) begin
          n_bad++;
          $display("FAIL hold_stable: got v=%b rdy=%b st=%0d cnt=%0d acc=%h, required v=1 rdy=0 st=2 cnt=%0d acc=%h",
                   w_out_valid, w_in_ready, w_dbg_state, w_cnt8, w_out_acc, ew[17:10], ew[7:0]);
        end
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({w_out_valid, w_in_ready, s_out_valid, s_in_ready} !== 4'b0101) begin
      n_bad++;
      $display("FAIL handoff: got v/rdy wrap=%b%b sat=%b%b, required 01 01",
               w_out_valid, w_in_ready, s_out_valid, s_in_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_cmp++;
    if ({w_out_valid, w_out_acc, w_out_of, w_sticky_of, w_op_count, w_dbg_state, w_in_ready}
        !== {1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b acc=%h of=%b st=%b cnt=%0d state=%0d rdy=%b, required all 0, rdy=1",
               w_out_valid, w_out_acc, w_out_of, w_sticky_of, w_op_count, w_dbg_state, w_in_ready);
    end
    run_cmd(2'b10, 8'h33, 1'b0, 1'b0, 0);
    // Accept an ADD, then reset for two cycles while it sits in EXEC.
    in_valid = 1'b1; in_cmd = 2'b00; in_data = 8'h44; in_ci = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_cmp++;
    if ({w_out_valid, w_out_acc, w_out_of, w_sticky_of, w_op_count, w_dbg_state, w_in_ready,
         w_add_op, w_add_ci, w_add_x, w_add_y}
        !== {1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      n_bad++;
      $display("FAIL reset_mid_exec: got v=%b acc=%h cnt=%0d state=%0d rdy=%b add=%b%b %h %h, required zeros, rdy=1",
               w_out_valid, w_out_acc, w_op_count, w_dbg_state, w_in_ready, w_add_op, w_add_ci, w_add_x, w_add_y);
    end
    n_cmp++;
    if ({s_out_valid, s_out_acc, s_op_count, s_dbg_state, s_in_ready} !== {1'b0, 8'h00, 8'h00, 2'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_mid_exec_sat: got v=%b acc=%h cnt=%0d state=%0d rdy=%b, required 0 00 0 0 1",
               s_out_valid, s_out_acc, s_op_count, s_dbg_state, s_in_ready);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (w_out_valid !== 1'b0 || s_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL dropped_cmd: got out_valid=%b/%b, required 0", w_out_valid, s_out_valid);
    end
  endtask

  task automatic test_add();
    run_cmd(2'b10, 8'h05, 1'b0, 1'b0, 0);
    run_cmd(2'b00, 8'h03, 1'b1, 1'b0, 0);
    n_cmp++;
    if ({w_out_acc, w_out_of, w_op_count, s_op_count} !== {8'h09, 1'b0, 2'd2, 8'd2}) begin
      n_bad++;
      $display("FAIL add_basic: got acc=%h of=%b cnt=%0d/%0d, required 09 0 2/2", w_out_acc, w_out_of, w_op_count, s_op_count);
    end
  endtask

  task automatic test_sub();
    run_cmd(2'b10, 8'h10, 1'b0, 1'b0, 0);
    run_cmd(2'b01, 8'h11, 1'b0, 1'b0, 0);
    n_cmp++;
    if (w_out_acc !== 8'hFF) begin
      n_bad++;
      $display("FAIL sub_borrow0: got acc=%h, required ff", w_out_acc);
    end
    run_cmd(2'b01, 8'h00, 1'b1, 1'b0, 0);
    n_cmp++;
    if (w_out_acc !== 8'hFE || s_out_acc !== 8'hFE) begin
      n_bad++;
      $display("FAIL sub_borrow1: got acc=%h/%h, required fe/fe", w_out_acc, s_out_acc);
    end
  endtask

  task automatic test_sat_add();
    run_cmd(2'b10, 8'h7F, 1'b0, 1'b0, 0);
    run_cmd(2'b00, 8'h01, 1'b0, 1'b0, 0);
    n_cmp++;
    if ({w_out_acc, w_out_of, w_sticky_of, s_out_acc, s_out_of, s_sticky_of}
        !== {8'h80, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL add_overflow: got wrap acc=%h of=%b st=%b sat acc=%h of=%b st=%b, required 80 1 1 / 7f 1 1",
               w_out_acc, w_out_of, w_sticky_of, s_out_acc, s_out_of, s_sticky_of);
    end
  endtask

  task automatic test_sat_sub_clear();
    run_cmd(2'b10, 8'h80, 1'b0, 1'b0, 0);
    run_cmd(2'b01, 8'h01, 1'b0, 1'b0, 0);
    n_cmp++;
    if ({s_out_acc, s_out_of, w_out_acc, w_out_of} !== {8'h80, 1'b1, 8'h7F, 1'b1}) begin
      n_bad++;
      $display("FAIL sub_overflow: got sat acc=%h of=%b wrap acc=%h of=%b, required 80 1 / 7f 1",
               s_out_acc, s_out_of, w_out_acc, w_out_of);
    end
    run_cmd(2'b00, 8'h00, 1'b0, 1'b0, 0);
    n_cmp++;
    if (s_sticky_of !== 1'b1 || s_out_of !== 1'b0) begin
      n_bad++;
      $display("FAIL sticky_hold: got sticky=%b of=%b, required 1 0", s_sticky_of, s_out_of);
    end
    run_cmd(2'b11, 8'h00, 1'b0, 1'b0, 0);
    n_cmp++;
    if ({w_out_acc, w_sticky_of, s_out_acc, s_sticky_of} !== {8'h00, 1'b0, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL clear: got acc=%h/%h sticky=%b/%b, required 00/00 0/0", w_out_acc, s_out_acc, w_sticky_of, s_sticky_of);
    end
  endtask

  task automatic test_hold_and_wrap();
    logic [1:0] start_cnt;
    run_cmd(2'b10, 8'h21, 1'b0, 1'b0, 5);
    start_cnt = w_op_count;
    run_cmd(2'b00, 8'h01, 1'b0, 1'b1, 0);
    run_cmd(2'b01, 8'h02, 1'b1, 1'b0, 0);
    run_cmd(2'b10, 8'hC0, 1'b0, 1'b1, 0);
    run_cmd(2'b11, 8'h00, 1'b0, 1'b0, 0);
    n_cmp++;
    if (w_op_count !== start_cnt) begin
      n_bad++;
      $display("FAIL count_wrap: got op_count=%0d, required %0d", w_op_count, start_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_cmd = 2'b00; in_data = 8'h00; in_ci = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_sat_add();
    test_sat_sub_clear();
    test_hold_and_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
